// File: rtl/dpll_pkg.sv
// -----------------------------------------------------------------------------
// dpll_pkg
// Shared definitions for the DCO frequency-lock controller:
//   - mode encodings driven on the controller's `mode` input
//   - controller state enumeration
//   - thermometer helper used to expand the trim index into the trim code
// -----------------------------------------------------------------------------
package dpll_pkg;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_HOLD   = 2'b01;
    localparam logic [1:0] MODE_MANUAL = 2'b10;

    typedef enum logic [2:0] {
        DISCARD,
        TRACK,
        UPDATE,
        HOLD,
        MANUAL
    } dpll_state_e;

    // One bit of the thermometer code: bit `pos` is set when it lies below
    // the index, so index N yields N ones in the LSBs.
    function automatic logic therm_bit(input int idx, input int pos);
        return pos < idx;
    endfunction

endpackage

// File: rtl/dpll_ref_sync.sv
// -----------------------------------------------------------------------------
// dpll_ref_sync
// Brings the asynchronous reference oscillator into the DCO clock domain and
// produces a one-cycle pulse on each of its rising edges.
// Ports:
//   clock   in  DCO clock
//   reset   in  synchronous active-high reset
//   osc     in  asynchronous reference oscillator
//   ref_evt out one-cycle pulse per synchronised rising edge of osc
// -----------------------------------------------------------------------------
module dpll_ref_sync (
    input  logic clock,
    input  logic reset,
    input  logic osc,
    output logic ref_evt
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = osc;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign ref_evt = sync2_q & ~prev_q;

endmodule

// File: rtl/dpll_lock_controller.sv
// -----------------------------------------------------------------------------
// dpll_lock_controller
// Counts DCO cycles per reference period and steps a thermometer trim code
// until the count sits within +/-TOL of the programmed division ratio.
// Ports:
//   clock      in  DCO clock, all logic on the rising edge
//   reset      in  synchronous active-high reset
//   osc        in  asynchronous reference oscillator
//   div        in  target DCO cycles per reference period (0 = no tracking)
//   mode       in  00 auto, 01/11 hold, 10 manual
//   ext_idx    in  trim index used in manual mode (clamped to TRIM_W)
//   trim       out thermometer trim code, trim[i] = (i < idx)
//   locked     out lock indicator
//   meas       out last completed period count
//   meas_valid out one-cycle pulse when meas updates
// -----------------------------------------------------------------------------
module dpll_lock_controller
    import dpll_pkg::*;
#(
    parameter int TRIM_W    = 26,
    parameter int DIV_W     = 5,
    parameter int CNT_W     = DIV_W + 2,
    parameter int TOL       = 1,
    parameter int COARSE_TH = 4,
    parameter int LOCK_N    = 8,
    parameter int TRIM_INIT = 13,
    parameter int IDX_W     = $clog2(TRIM_W + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              osc,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        mode,
    input  logic [IDX_W-1:0]  ext_idx,
    output logic [TRIM_W-1:0] trim,
    output logic              locked,
    output logic [CNT_W-1:0]  meas,
    output logic              meas_valid
);

    localparam int ERR_W = CNT_W + 1;
    localparam int LCK_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0]        CNT_MAX  = {CNT_W{1'b1}};
    localparam logic signed [ERR_W-1:0] TOL_S    = ERR_W'(TOL);
    localparam logic signed [ERR_W-1:0] COARSE_S = ERR_W'(COARSE_TH);
    localparam logic [LCK_W-1:0]        LOCK_MAX = LCK_W'(LOCK_N);
    localparam logic [IDX_W-1:0]        IDX_MAX  = IDX_W'(TRIM_W);
    localparam logic [IDX_W-1:0]        IDX_INIT = IDX_W'(TRIM_INIT);

    logic ref_evt;

    dpll_ref_sync u_ref_sync (
        .clock   (clock),
        .reset   (reset),
        .osc     (osc),
        .ref_evt (ref_evt)
    );

    dpll_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  meas_q, meas_d;
    logic              meas_valid_q, meas_valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;

    logic                    manual_req;
    logic                    hold_mode;
    logic                    run_auto;
    logic                    meas_sat;
    logic signed [ERR_W-1:0] err;
    logic signed [ERR_W-1:0] err_mag;
    logic                    too_fast;
    logic                    too_slow;
    logic                    in_band;
    logic [IDX_W-1:0]        step;
    logic [IDX_W-1:0]        idx_up;
    logic [IDX_W-1:0]        idx_dn;
    logic [IDX_W-1:0]        ext_clamped;

    // Mode 11 is an alias of hold; div = 0 also parks the loop in hold.
    assign manual_req = (mode == MODE_MANUAL);
    assign hold_mode  = (mode == MODE_HOLD) || (mode == (MODE_HOLD | MODE_MANUAL));
    assign run_auto   = !manual_req && !hold_mode && (div != '0);

    // Period counter; a discarded edge only restarts it without publishing.
    always_comb begin
        cnt_d        = cnt_q;
        meas_d       = meas_q;
        meas_valid_d = 1'b0;
        if (ref_evt) begin
            cnt_d = '0;
            if (state_q != DISCARD) begin
                meas_d       = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                meas_valid_d = 1'b1;
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A saturated measurement means the DCO ran far too fast to count.
    always_comb begin
        meas_sat = (meas_q == CNT_MAX);
        err      = $signed({1'b0, meas_q}) - $signed({{(ERR_W-DIV_W){1'b0}}, div});
        err_mag  = err[ERR_W-1] ? -err : err;
        too_fast = meas_sat || (err > TOL_S);
        too_slow = !too_fast && (err < -TOL_S);
        in_band  = !too_fast && !too_slow;
        step     = (meas_sat || (err_mag > COARSE_S)) ? IDX_W'(2) : IDX_W'(1);
        // idx_q never exceeds IDX_MAX, so the headroom subtraction cannot wrap.
        idx_up      = ((IDX_MAX - idx_q) <= step) ? IDX_MAX : idx_q + step;
        idx_dn      = (idx_q <= step) ? '0 : idx_q - step;
        ext_clamped = (ext_idx > IDX_MAX) ? IDX_MAX : ext_idx;
    end

    // Any path out of hold/manual back into auto passes through DISCARD, which
    // covers both a mode change into auto and div going from 0 to non-zero.
    always_comb begin
        state_d = state_q;
        if (manual_req) begin
            state_d = MANUAL;
        end else if (!run_auto) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                DISCARD:       if (ref_evt) state_d = TRACK;
                TRACK, UPDATE: state_d = ref_evt ? UPDATE : TRACK;
                default:       state_d = DISCARD;
            endcase
        end
    end

    // Trim index and lock counter. Manual follows ext_idx straight from the
    // input so trim lags it by exactly one clock, even on entry to manual.
    always_comb begin
        idx_d      = idx_q;
        lock_cnt_d = lock_cnt_q;
        if (manual_req) begin
            idx_d      = ext_clamped;
            lock_cnt_d = '0;
        end else if (!run_auto) begin
            lock_cnt_d = '0;
        end else if (state_q == UPDATE) begin
            if (in_band) begin
                if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_d = '0;
                idx_d      = too_fast ? idx_up : idx_dn;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= DISCARD;
            cnt_q        <= '0;
            meas_q       <= '0;
            meas_valid_q <= 1'b0;
            idx_q        <= IDX_INIT;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            meas_q       <= meas_d;
            meas_valid_q <= meas_valid_d;
            idx_q        <= idx_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    // An out-of-band measurement drops locked already during its UPDATE cycle.
    assign locked     = (lock_cnt_q == LOCK_MAX) && !((state_q == UPDATE) && !in_band);
    assign meas       = meas_q;
    assign meas_valid = meas_valid_q;

    for (genvar i = 0; i < TRIM_W; i++) begin : g_trim
        assign trim[i] = therm_bit(int'(idx_q), i);
    end

endmodule
